// File: rtl/op_sequencer.sv
// ---------------------------------------------------------------------------
// op_sequencer
//
// Purpose:
//   Command sequencer that sits between the UART receive-side frame
//   collector, the shared ALU and the UART transmitter. It accepts one
//   command at a time (opcode, operand A, operand B). It rejects illegal
//   opcodes, launches the ALU and watches it with a watchdog. It then
//   returns a response frame of status, result high byte and result low
//   byte through the UART TX handshake.
//
// Optional feature:
//   OP_SEQUENCER_CHECKSUM_EN - when defined, a fourth response byte is
//   sent: status ^ result[15:8] ^ result[7:0]. When it is not defined, the
//   response is exactly three bytes and no checksum logic exists.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous reset, active-low
//   cmd_valid    command frame present
//   cmd_op       opcode
//   cmd_a        operand A
//   cmd_b        operand B
//   cmd_ready    high only in IDLE; a command is accepted on valid && ready
//   alu_start    one-cycle launch pulse to the ALU
//   alu_op       registered opcode to the ALU
//   alu_a        registered operand A to the ALU
//   alu_b        registered operand B to the ALU
//   alu_done     ALU result valid, single-cycle pulse
//   alu_result   ALU result, 2*DATA_W bits
//   alu_error    ALU fault, qualified by alu_done
//   tx_start     one-cycle UART transmit request
//   tx_data      byte to transmit; held until the next tx_start
//   tx_busy      UART transmitter busy
//   busy         high in every state except IDLE
//   err_count    number of non-OK responses; saturates at 255
//
// DATA_W must be at least 8 because the response splits the result into
// the bytes result[15:8] and result[7:0].
// ---------------------------------------------------------------------------
module op_sequencer #(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int OP_MAX      = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  input  logic [DATA_W-1:0]     cmd_op,
  input  logic [DATA_W-1:0]     cmd_a,
  input  logic [DATA_W-1:0]     cmd_b,
  output logic                  cmd_ready,
  output logic                  alu_start,
  output logic [DATA_W-1:0]     alu_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic                  alu_done,
  input  logic [2*DATA_W-1:0]   alu_result,
  input  logic                  alu_error,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] OP_LIMIT = DATA_W'(OP_MAX);

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_ALU_ERR = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT = 8'hE2;
  localparam logic [7:0] ST_BAD_OP  = 8'hE3;

`ifdef OP_SEQUENCER_CHECKSUM_EN
  typedef enum logic [3:0] {
    IDLE, CHECK, ISSUE, WAIT_ALU,
    SEND_ST, WAIT_ST, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO,
    SEND_CK, WAIT_CK
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, CHECK, ISSUE, WAIT_ALU,
    SEND_ST, WAIT_ST, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO
  } state_t;
`endif

  state_t                state, state_n;
  logic [DATA_W-1:0]     op_n, a_n, b_n;
  logic [7:0]            status_q, status_n;
  logic [2*DATA_W-1:0]   result_q, result_n;
  logic [CNT_W-1:0]      wd_cnt, wd_cnt_n;
  logic                  tx_start_n;
  logic [7:0]            tx_data_n;
  logic [7:0]            err_count_n;

`ifdef OP_SEQUENCER_CHECKSUM_EN
  logic [7:0] ck_byte;
  assign ck_byte = status_q ^ result_q[15:8] ^ result_q[7:0];
`endif

  // These handshake outputs decode straight from the state register, so
  // reset forces them to their idle values immediately.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign alu_start = (state == ISSUE);

  // State and datapath registers. Reset aborts any response in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      status_q  <= '0;
      result_q  <= '0;
      wd_cnt    <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      alu_op    <= op_n;
      alu_a     <= a_n;
      alu_b     <= b_n;
      status_q  <= status_n;
      result_q  <= result_n;
      wd_cnt    <= wd_cnt_n;
      tx_start  <= tx_start_n;
      tx_data   <= tx_data_n;
      err_count <= err_count_n;
    end
  end

  // Next-state and next-datapath logic.
  // tx_start is registered, so it is high exactly in the first cycle of
  // each WAIT_x state. That is the cycle in which the UART has not yet
  // raised tx_busy, so WAIT_x uses tx_start to skip tx_busy in that cycle.
  always_comb begin
    state_n     = state;
    op_n        = alu_op;
    a_n         = alu_a;
    b_n         = alu_b;
    status_n    = status_q;
    result_n    = result_q;
    wd_cnt_n    = wd_cnt;
    tx_start_n  = 1'b0;
    tx_data_n   = tx_data;
    err_count_n = err_count;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_n    = cmd_op;
          a_n     = cmd_a;
          b_n     = cmd_b;
          state_n = CHECK;
        end
      end

      CHECK: begin
        if (alu_op > OP_LIMIT) begin
          status_n = ST_BAD_OP;
          result_n = '0;
          state_n  = SEND_ST;
        end else begin
          state_n = ISSUE;
        end
      end

      ISSUE: begin
        wd_cnt_n = '0;
        state_n  = WAIT_ALU;
      end

      // alu_done is checked before the watchdog, so a result that arrives
      // in the last watchdog cycle is still reported as a success.
      WAIT_ALU: begin
        if (alu_done) begin
          if (alu_error) begin
            status_n = ST_ALU_ERR;
            result_n = '0;
          end else begin
            status_n = ST_OK;
            result_n = alu_result;
          end
          state_n = SEND_ST;
        end else if (wd_cnt == CNT_LAST) begin
          status_n = ST_TIMEOUT;
          result_n = '0;
          state_n  = SEND_ST;
        end else begin
          wd_cnt_n = wd_cnt + CNT_W'(1);
        end
      end

      SEND_ST: begin
        if (!tx_busy) begin
          tx_start_n = 1'b1;
          tx_data_n  = status_q;
          if ((status_q != ST_OK) && (err_count != 8'hFF)) begin
            err_count_n = err_count + 8'd1;
          end
          state_n = WAIT_ST;
        end
      end

      WAIT_ST: begin
        if (!tx_start && !tx_busy) state_n = SEND_HI;
      end

      SEND_HI: begin
        if (!tx_busy) begin
          tx_start_n = 1'b1;
          tx_data_n  = result_q[15:8];
          state_n    = WAIT_HI;
        end
      end

      WAIT_HI: begin
        if (!tx_start && !tx_busy) state_n = SEND_LO;
      end

      SEND_LO: begin
        if (!tx_busy) begin
          tx_start_n = 1'b1;
          tx_data_n  = result_q[7:0];
          state_n    = WAIT_LO;
        end
      end

      WAIT_LO: begin
`ifdef OP_SEQUENCER_CHECKSUM_EN
        if (!tx_start && !tx_busy) state_n = SEND_CK;
`else
        if (!tx_start && !tx_busy) state_n = IDLE;
`endif
      end

`ifdef OP_SEQUENCER_CHECKSUM_EN
      SEND_CK: begin
        if (!tx_busy) begin
          tx_start_n = 1'b1;
          tx_data_n  = ck_byte;
          state_n    = WAIT_CK;
        end
      end

      WAIT_CK: begin
        if (!tx_start && !tx_busy) state_n = IDLE;
      end
`endif

      default: state_n = IDLE;
    endcase
  end

endmodule
